// File: rtl/countdown_mmss.sv
// countdown_mmss: microwave cook-time countdown, BCD MM:SS (max 99:59).
// The 1 s time base (sec_clk) is sampled as data in the clk_in domain. By default
// a rising edge of sec_clk is one tick; with EDGE_DETECT=0 every high cycle is a tick.
// Ports:
//   clk_in, rst_n                 system clock, synchronous active-low reset
//   sec_clk                       time base from the clock divider
//   load, ld_mt/ld_mo/ld_st/ld_so load strobe and BCD digits to load (clamped)
//   start, stop, clear            command strobes
//   mt, mo, st, so                current count, BCD, registered
//   running, done, done_pulse     status: RUNNING, DONE level, 1-cycle DONE entry pulse
module countdown_mmss #(
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       sec_clk,
  input  logic       load,
  input  logic [3:0] ld_mt,
  input  logic [3:0] ld_mo,
  input  logic [3:0] ld_st,
  input  logic [3:0] ld_so,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);

  typedef enum logic [1:0] {StIdle, StPaused, StRunning, StDone} state_e;

  state_e     r_state, w_state_d;
  logic [3:0] r_mt, r_mo, r_st, r_so;
  logic [3:0] w_mt_d, w_mo_d, w_st_d, w_so_d;
  logic       r_sec_q;
  logic       r_running, r_done, r_done_pulse;
  logic       w_done_pulse_d;
  logic       w_tick;
  logic       w_is_zero;
  logic       w_is_one;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign w_tick    = EDGE_DETECT ? (sec_clk & ~r_sec_q) : sec_clk;
  assign w_is_zero = ({r_mt, r_mo, r_st, r_so} == 16'h0000);
  assign w_is_one  = ({r_mt, r_mo, r_st, r_so} == 16'h0001);

  // Command priority: clear > load > stop > start > tick. A command that is not
  // applicable in the current state is ignored and does not mask lower ones.
  always_comb begin
    w_state_d      = r_state;
    w_mt_d         = r_mt;
    w_mo_d         = r_mo;
    w_st_d         = r_st;
    w_so_d         = r_so;
    w_done_pulse_d = 1'b0;
    if (clear) begin
      w_state_d = StIdle;
      w_mt_d    = 4'd0;
      w_mo_d    = 4'd0;
      w_st_d    = 4'd0;
      w_so_d    = 4'd0;
    end else if (load && (r_state != StRunning)) begin
      w_state_d = StPaused;
      w_mt_d    = clamp(ld_mt, 4'd9);
      w_mo_d    = clamp(ld_mo, 4'd9);
      w_st_d    = clamp(ld_st, 4'd5);
      w_so_d    = clamp(ld_so, 4'd9);
    end else if (stop && (r_state == StRunning)) begin
      w_state_d = StPaused;
    end else if (start && (r_state == StPaused) && !w_is_zero) begin
      w_state_d = StRunning;
    end else if (w_tick && (r_state == StRunning)) begin
      // RUNNING always holds a non-zero count, so the final borrow into mt is safe.
      if (r_so != 4'd0) begin
        w_so_d = r_so - 4'd1;
      end else begin
        w_so_d = 4'd9;
        if (r_st != 4'd0) begin
          w_st_d = r_st - 4'd1;
        end else begin
          w_st_d = 4'd5;
          if (r_mo != 4'd0) begin
            w_mo_d = r_mo - 4'd1;
          end else begin
            w_mo_d = 4'd9;
            w_mt_d = r_mt - 4'd1;
          end
        end
      end
      if (w_is_one) begin
        w_state_d      = StDone;
        w_done_pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_mt         <= 4'd0;
      r_mo         <= 4'd0;
      r_st         <= 4'd0;
      r_so         <= 4'd0;
      // History starts high so a sec_clk already high at release is not a tick.
      r_sec_q      <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_done_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_mt         <= w_mt_d;
      r_mo         <= w_mo_d;
      r_st         <= w_st_d;
      r_so         <= w_so_d;
      r_sec_q      <= sec_clk;
      r_running    <= (w_state_d == StRunning);
      r_done       <= (w_state_d == StDone);
      r_done_pulse <= w_done_pulse_d;
    end
  end

  assign mt         = r_mt;
  assign mo         = r_mo;
  assign st         = r_st;
  assign so         = r_so;
  assign running    = r_running;
  assign done       = r_done;
  assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_countdown_mmss.sv
// Self-checking bench for countdown_mmss: a directed vector table, hand-written
// reset sequences, and a randomized run against a seconds-count reference model.
module tb_countdown_mmss;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       sec_clk;
  logic       load;
  logic [3:0] ld_mt, ld_mo, ld_st, ld_so;
  logic       start, stop, clear;
  logic [3:0] mt, mo, st, so;
  logic       running, done, done_pulse;

  int checks = 0;
  int errors = 0;

  countdown_mmss #(.EDGE_DETECT(1'b1)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sec_clk   (sec_clk),
    .load      (load),
    .ld_mt     (ld_mt),
    .ld_mo     (ld_mo),
    .ld_st     (ld_st),
    .ld_so     (ld_so),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .mt        (mt),
    .mo        (mo),
    .st        (st),
    .so        (so),
    .running   (running),
    .done      (done),
    .done_pulse(done_pulse)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        s;
    logic        ld;
    logic [15:0] dig;
    logic        sa;
    logic        sp;
    logic        cl;
    logic [15:0] e_dig;
    logic        e_run;
    logic        e_done;
    logic        e_dp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic s, input logic ld, input logic [15:0] dig,
                             input logic sa, input logic sp, input logic cl,
                             input logic [15:0] e_dig, input logic e_run,
                             input logic e_done, input logic e_dp);
    vec_t r;
    r.s = s; r.ld = ld; r.dig = dig; r.sa = sa; r.sp = sp; r.cl = cl;
    r.e_dig = e_dig; r.e_run = e_run; r.e_done = e_done; r.e_dp = e_dp;
    return r;
  endfunction

  task automatic drive(input logic s, input logic ld, input logic [15:0] dig,
                       input logic sa, input logic sp, input logic cl);
    sec_clk = s;
    load    = ld;
    {ld_mt, ld_mo, ld_st, ld_so} = dig;
    start   = sa;
    stop    = sp;
    clear   = cl;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] e_dig, input logic e_run,
                       input logic e_done, input logic e_dp);
    logic [18:0] got, exp;
    got = {mt, mo, st, so, running, done, done_pulse};
    exp = {e_dig, e_run, e_done, e_dp};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h:%h run=%b done=%b dp=%b, expected %h:%h run=%b done=%b dp=%b",
               name, got[18:11], got[10:3], got[2], got[1], got[0],
               exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic do_reset(input logic s);
    rst_n = 1'b0;
    drive(s, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Reference model: count kept as plain seconds; state as small integers.
  localparam int MIdle = 0, MPaused = 1, MRun = 2, MDone = 3;
  int m_secs;
  int m_state;
  bit m_prev;
  bit m_dp;

  function automatic int clampi(input int x, input int lim);
    return (x > lim) ? lim : x;
  endfunction

  task automatic model_reset();
    m_secs = 0; m_state = MIdle; m_prev = 1'b1; m_dp = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic ld, input logic [15:0] dig,
                            input logic sa, input logic sp, input logic cl);
    bit tick;
    tick   = s && !m_prev;
    m_prev = s;
    m_dp   = 1'b0;
    if (cl) begin
      m_secs = 0; m_state = MIdle;
    end else if (ld && m_state != MRun) begin
      m_secs = clampi(int'(dig[15:12]), 9) * 600 + clampi(int'(dig[11:8]), 9) * 60
             + clampi(int'(dig[7:4]), 5) * 10 + clampi(int'(dig[3:0]), 9);
      m_state = MPaused;
    end else if (sp && m_state == MRun) begin
      m_state = MPaused;
    end else if (sa && m_state == MPaused && m_secs != 0) begin
      m_state = MRun;
    end else if (tick && m_state == MRun) begin
      m_secs--;
      if (m_secs == 0) begin
        m_state = MDone;
        m_dp    = 1'b1;
      end
    end
  endtask

  function automatic logic [15:0] model_bcd();
    int m, s;
    m = m_secs / 60;
    s = m_secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  initial begin
    logic s, ld, sa, sp, cl;
    logic [15:0] dig;

    // Reset with sec_clk high; release with it still high: no tick, 00:00 IDLE.
    do_reset(1'b1);
    check("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    check("release_sec_high", 16'h0000, 1'b0, 1'b0, 1'b0);
    // Load while sec_clk stays high, start: held-high sec_clk must not decrement.
    drive(1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    check("sec_high_no_tick", 16'h0005, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    step();
    check("clear_running", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Directed table: s ld dig sa sp cl | expected digits run done dp
    vecs.push_back(v(0, 1, 16'h0100, 0, 0, 0, 16'h0100, 0, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 0, 16'h0100, 1, 0, 0));
    vecs.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0059, 1, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0059, 1, 0, 0));
    vecs.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0058, 1, 0, 0));
    vecs.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0058, 1, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0058, 1, 0, 0));
    vecs.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0057, 1, 0, 0));
    vecs.push_back(v(0, 1, 16'h0002, 0, 0, 0, 16'h0057, 1, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0057, 0, 0, 0));
    vecs.push_back(v(0, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, 0));
    vecs.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0001, 1, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0001, 1, 0, 0));
    vecs.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 1));
    vecs.push_back(v(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0));
    vecs.push_back(v(0, 1, 16'h007c, 0, 0, 0, 16'h0059, 0, 0, 0));
    vecs.push_back(v(0, 1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0, 0));
    vecs.push_back(v(1, 0, 16'h0000, 0, 1, 0, 16'h1000, 0, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 0, 16'h1000, 1, 0, 0));
    vecs.push_back(v(1, 1, 16'h0003, 1, 0, 0, 16'h0959, 1, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 0, 1, 0, 16'h0959, 0, 0, 0));
    vecs.push_back(v(0, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(0, 1, 16'h0530, 0, 0, 0, 16'h0530, 0, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 0, 16'h0530, 1, 0, 0));
    vecs.push_back(v(1, 1, 16'h1234, 0, 0, 1, 16'h0000, 0, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0));
    vecs.push_back(v(0, 1, 16'hcf9f, 0, 0, 0, 16'h9959, 0, 0, 0));
    vecs.push_back(v(0, 0, 16'h0000, 1, 0, 0, 16'h9959, 1, 0, 0));
    vecs.push_back(v(1, 0, 16'h0000, 0, 0, 0, 16'h9958, 1, 0, 0));

    do_reset(1'b0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].s, vecs[i].ld, vecs[i].dig, vecs[i].sa, vecs[i].sp, vecs[i].cl);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_dig, vecs[i].e_run, vecs[i].e_done,
            vecs[i].e_dp);
    end

    // Reset asserted mid-countdown with other commands active: fully reset next cycle.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 16'h0321, 1'b1, 1'b0, 1'b0);
    step();
    check("reset_mid_run", 16'h0000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step();
    check("start_in_idle", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Randomized run against the reference model.
    do_reset(1'b0);
    model_reset();
    s = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 2) == 0) s = ~s;
      ld  = ($urandom_range(0, 24) == 0);
      sa  = ($urandom_range(0, 7) == 0);
      sp  = ($urandom_range(0, 40) == 0);
      cl  = ($urandom_range(0, 150) == 0);
      dig[15:12] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      dig[11:8]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      dig[7:4]   = 4'($urandom_range(0, 15));
      dig[3:0]   = 4'($urandom_range(0, 15));
      drive(s, ld, dig, sa, sp, cl);
      model_step(s, ld, dig, sa, sp, cl);
      step();
      check($sformatf("rand%0d", n), model_bcd(), m_state == MRun, m_state == MDone, m_dp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
